sign_fmt_conv_pipe: RTL and testbench

//  Parametrised, pipelined two-way converter between two's-complement (2C) and sign-magnitude (SM) formats.
//  A per-transaction mode bit selects 2C->SM or SM->2C. Results carry flags for the unrepresentable 2C minimum and for SM negative zero.
//  A saturating counter counts flagged conversions.

---
 rtl/sign_fmt_pkg.sv | 19 +
 rtl/sign_fmt_conv_pipe_cond_negate.sv | 24 ++
 rtl/sign_fmt_conv_pipe.sv | 111 +++++++++++
 tb/tb_sign_fmt_conv_pipe.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sign_fmt_pkg.sv
// Shared definitions for the two's-complement / sign-magnitude converter.
package sign_fmt_pkg;

  localparam logic MODE_2C_TO_SM = 1'b0;
  localparam logic MODE_SM_TO_2C = 1'b1;

  // Widest operand the is_min helper handles; callers zero-extend into it.
  localparam int MAX_W = 64;

  typedef struct packed {
    logic ovf;
    logic negz;
  } conv_flags_t;

  function automatic logic is_min(input logic [MAX_W-1:0] x, input int unsigned n);
    return x == (MAX_W'(1) << (n - 1));
  endfunction

endpackage

// File: rtl/sign_fmt_conv_pipe_cond_negate.sv
// Conditional two's negate: y = inv ? ~a + 1 : a, built as an invert stage
// followed by a half-adder ripple chain that injects the +1.
module cond_negate #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic         inv,
  output logic [N-1:0] y
);

  logic [N-1:0] b;
  logic [N-1:0] c;

  assign b    = a ^ {N{inv}};
  assign c[0] = inv;

  for (genvar i = 0; i < N; i++) begin : g_ha
    assign y[i] = b[i] ^ c[i];
    if (i < N - 1) begin : g_carry
      assign c[i+1] = b[i] & c[i];
    end
  end

endmodule

// File: rtl/sign_fmt_conv_pipe.sv
// Two-stage valid/ready pipeline converting between 2C and SM per transaction,
// with min/negative-zero flags and a saturating count of flagged outputs.
module sign_fmt_conv_pipe
  import sign_fmt_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic             out_ovf,
  output logic             out_negz,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             err_clr
);

  logic         s1_valid;
  logic         s1_mode;
  logic [N-1:0] s1_data;
  logic         s2_valid;
  logic         s1_load;
  logic         s2_load;
  logic         out_xfer;

  assign s2_load   = s1_valid & (~s2_valid | out_ready);
  assign in_ready  = ~s1_valid | s2_load;
  assign s1_load   = in_valid & in_ready;
  assign out_valid = s2_valid;
  assign out_xfer  = s2_valid & out_ready;

  logic         sgn;
  logic         min_in;
  logic [N-1:0] neg_in;
  logic [N-1:0] neg_out;
  logic [N-1:0] res;
  conv_flags_t  flg;

  assign sgn    = s1_data[N-1];
  assign min_in = is_min(MAX_W'(s1_data), N);
  // SM->2C negates the magnitude only; 2C->SM negates the whole word.
  assign neg_in = (s1_mode == MODE_SM_TO_2C) ? {1'b0, s1_data[N-2:0]} : s1_data;

  cond_negate #(.N(N)) u_neg (
    .a   (neg_in),
    .inv (sgn),
    .y   (neg_out)
  );

  always_comb begin
    res = neg_out;
    flg = '0;
    if (s1_mode == MODE_2C_TO_SM) begin
      if (min_in) begin
        res     = '1;
        flg.ovf = 1'b1;
      end else if (sgn) begin
        res = {1'b1, neg_out[N-2:0]};
      end
    end else if (min_in) begin
      res      = '0;
      flg.negz = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mode  <= MODE_2C_TO_SM;
      s1_data  <= '0;
    end else if (s1_load) begin
      s1_valid <= 1'b1;
      s1_mode  <= in_mode;
      s1_data  <= in_data;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Result and flags only change on a load, so they hold through a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      out_data <= '0;
      out_ovf  <= 1'b0;
      out_negz <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      out_data <= res;
      out_ovf  <= flg.ovf;
      out_negz <= flg.negz;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      err_cnt <= '0;
    end else if (out_xfer && (out_ovf || out_negz) && !(&err_cnt)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sign_fmt_conv_pipe.sv
// Randomized scoreboard bench for sign_fmt_conv_pipe (N=8) with a second
// instance at CNT_W=2 to exercise counter saturation.
module tb_sign_fmt_conv_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_mode = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b1;
  logic       err_clr = 1'b0;

  logic       in_ready, out_valid, out_ovf, out_negz;
  logic [7:0] out_data, err_cnt;
  logic       in_ready2, out_valid2, out_ovf2, out_negz2;
  logic [7:0] out_data2;
  logic [1:0] err_cnt2;

  sign_fmt_conv_pipe #(.N(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf),
    .out_negz(out_negz), .err_cnt(err_cnt), .err_clr(err_clr)
  );

  sign_fmt_conv_pipe #(.N(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_mode(in_mode), .in_data(in_data), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .out_ovf(out_ovf2),
    .out_negz(out_negz2), .err_cnt(err_cnt2), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [7:0] d;
    logic       ovf;
    logic       negz;
    int         t;
    bit         lat;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference: interpret the word as a signed/magnitude number and re-encode.
  function automatic exp_t ref_model(input bit m, input logic [7:0] x);
    exp_t e;
    int v, mag;
    e.ovf = 1'b0; e.negz = 1'b0; e.t = 0; e.lat = 1'b0; e.d = 8'h00;
    if (!m) begin
      v = (int'(x) >= 128) ? int'(x) - 256 : int'(x);
      if (v == -128) begin
        e.d = 8'hFF; e.ovf = 1'b1;
      end else if (v < 0) e.d = 8'(128 + (-v));
      else e.d = 8'(v);
    end else begin
      mag = int'(x) % 128;
      if (int'(x) >= 128) begin
        if (mag == 0) begin
          e.d = 8'h00; e.negz = 1'b1;
        end else e.d = 8'(256 - mag);
      end else e.d = x;
    end
    return e;
  endfunction

  bit rdy_rand = 1'b0;
  bit rdy_val = 1'b1;
  always @(posedge clk) begin
    #2;
    out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
  end

  // Monitor / scoreboard
  bit         stall = 1'b0;
  logic [7:0] hold_d;
  logic       hold_o, hold_n;
  int         cnt8_m = 0;
  int         cnt2_m = 0;

  always @(negedge clk) begin
    exp_t e;
    bit flagged;
    if (rst) begin
      q.delete();
      stall  = 1'b0;
      cnt8_m = 0;
      cnt2_m = 0;
    end else begin
      flagged = 1'b0;
      chk(err_cnt == 8'(cnt8_m), "err_cnt", err_cnt, cnt8_m);
      chk(err_cnt2 == 2'(cnt2_m), "err_cnt_w2", err_cnt2, cnt2_m);
      if (stall && out_valid)
        chk(out_data == hold_d && out_ovf == hold_o && out_negz == hold_n,
            "hold_stable", {out_ovf, out_negz, out_data}, {hold_o, hold_n, hold_d});
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk(1'b0, "unexpected_out", out_data, 0);
        else begin
          e = q.pop_front();
          chk({out_ovf, out_negz, out_data} == {e.ovf, e.negz, e.d}, "out_word",
              {out_ovf, out_negz, out_data}, {e.ovf, e.negz, e.d});
          chk(out_valid2 && {out_ovf2, out_negz2, out_data2} == {e.ovf, e.negz, e.d},
              "out_word_w2", {out_valid2, out_ovf2, out_negz2, out_data2}, {1'b1, e.ovf, e.negz, e.d});
          if (e.lat) chk(cyc - e.t == 2, "latency", cyc - e.t, 2);
          flagged = e.ovf | e.negz;
        end
      end
      if (err_clr) begin
        cnt8_m = 0; cnt2_m = 0;
      end else if (flagged) begin
        if (cnt8_m < 255) cnt8_m++;
        if (cnt2_m < 3) cnt2_m++;
      end
      stall  = out_valid && !out_ready;
      hold_d = out_data; hold_o = out_ovf; hold_n = out_negz;
    end
  end

  task automatic send(input bit m, input logic [7:0] d, input bit lat);
    exp_t e;
    int k;
    @(posedge clk); #1;
    in_valid = 1'b1; in_mode = m; in_data = d;
    k = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        e = ref_model(m, d); e.t = cyc; e.lat = lat;
        q.push_back(e);
        break;
      end
      k++;
      if (k > 200) begin
        chk(1'b0, "accept_timeout", k, 0);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (n - 1) @(posedge clk);
  endtask

  initial begin
    logic [7:0] w [3];
    int idx, k;
    exp_t e;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
    chk(out_data == 8'h00, "rst_out_data", out_data, 0);
    chk(out_ovf == 1'b0 && out_negz == 1'b0, "rst_flags", {out_ovf, out_negz}, 0);
    chk(err_cnt == 8'h00, "rst_err_cnt", err_cnt, 0);
    chk(in_ready == 1'b1 && in_ready2 == 1'b1, "rst_in_ready", {in_ready, in_ready2}, 2'b11);

    // Back-to-back 2C->SM stream
    send(0, 8'h05, 1); send(0, 8'hFB, 1); send(0, 8'h00, 1);
    idle(4);

    // Flag cases
    send(0, 8'h80, 1); idle(4);
    chk(err_cnt == 8'd1, "ovf_count", err_cnt, 1);
    send(1, 8'h80, 1); idle(4);
    chk(err_cnt == 8'd2, "negz_count", err_cnt, 2);

    // SM->2C directed, then exhaustive both modes
    send(1, 8'h85, 1); send(1, 8'hFF, 1); send(1, 8'h7F, 1);
    for (int x = 0; x < 256; x++) send(0, 8'(x), 1);
    for (int x = 0; x < 256; x++) send(1, 8'(x), 1);
    idle(4);

    // Backpressure: 5 stalled cycles, 3 words offered
    w[0] = 8'h11; w[1] = 8'h9C; w[2] = 8'h80;
    rdy_val = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      in_valid = (idx < 3); in_mode = 1'b0; in_data = w[idx < 3 ? idx : 2];
      @(negedge clk);
      if (in_valid && in_ready) begin
        e = ref_model(0, in_data); e.t = cyc; e.lat = 1'b0;
        q.push_back(e);
        idx++;
      end
    end
    chk(idx == 2, "bp_accepted", idx, 2);
    chk(in_ready == 1'b0, "bp_in_ready", in_ready, 0);
    chk(out_valid == 1'b1, "bp_out_valid", out_valid, 1);
    rdy_val = 1'b1;
    send(0, w[2], 0);
    idle(5);

    // Reset with both stages full
    rdy_val = 1'b0;
    send(1, 8'h83, 0); send(1, 8'h04, 0);
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; rdy_val = 1'b1;
    @(negedge clk);
    chk(out_valid == 1'b0, "rst_mid_out_valid", out_valid, 0);
    chk(err_cnt == 8'h00, "rst_mid_err_cnt", err_cnt, 0);
    chk(in_ready == 1'b1, "rst_mid_in_ready", in_ready, 1);
    send(0, 8'hF0, 1); idle(4);

    // Counter saturation and clear priority
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    for (int i = 0; i < 5; i++) send(0, 8'h80, 1);
    idle(4);
    chk(err_cnt2 == 2'd3, "sat_w2", err_cnt2, 3);
    chk(err_cnt == 8'd5, "cnt_w8_five", err_cnt, 5);
    @(posedge clk); #1 err_clr = 1'b1;
    send(0, 8'h80, 1); idle(4);
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    chk(err_cnt == 8'd0 && err_cnt2 == 2'd0, "clr_priority", {err_cnt, 6'd0, err_cnt2}, 0);

    // Randomized traffic with random backpressure
    rdy_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      send(1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom), 0);
      if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 3));
    end
    idle(1);
    rdy_rand = 1'b0;
    k = 0;
    while (q.size() > 0 && k < 500) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
    chk(q.size() == 0, "drain", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
